regfile_mp: RTL and testbench

- Multi-ported integer register file for LemonPC, sized for dual-issue.
- N read ports and M write ports, with optional same-cycle write-to-read bypass.
- Per-register pending (busy) scoreboard for hazard detection.
- Sequential clear engine that zeroes the whole file on request, one entry per cycle.
- Entry 0 always reads as zero.

---
 rtl/regfile_mp_if.sv | 30 +++
 rtl/regfile_mp.sv | 139 +++++++++++++
 tb/tb_regfile_mp.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-ported register file: read/write ports,
// scoreboard set port and clear-engine handshake.
interface regfile_mp_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int NR_READ    = 2,
  parameter int NR_WRITE   = 2
);
  logic [NR_READ*ADDR_WIDTH-1:0]  raddr;
  logic [NR_READ*DATA_WIDTH-1:0]  rdata;
  logic [NR_READ-1:0]             rbusy;
  logic [NR_WRITE-1:0]            wen;
  logic [NR_WRITE*ADDR_WIDTH-1:0] waddr;
  logic [NR_WRITE*DATA_WIDTH-1:0] wdata;
  logic                           busy_set;
  logic [ADDR_WIDTH-1:0]          busy_addr;
  logic                           clr_req;
  logic                           clr_ready;
  logic                           clr_done;

  modport master (
    output raddr, wen, waddr, wdata, busy_set, busy_addr, clr_req,
    input  rdata, rbusy, clr_ready, clr_done
  );

  modport slave (
    input  raddr, wen, waddr, wdata, busy_set, busy_addr, clr_req,
    output rdata, rbusy, clr_ready, clr_done
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-ported integer register file with optional write-to-read bypass,
// per-register pending scoreboard and a one-entry-per-cycle clear engine.
module regfile_mp #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int NR_READ    = 2,
  parameter int NR_WRITE   = 2,
  parameter int BYPASS     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  regfile_mp_if.slave bus
);
  localparam int N_REG = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N_REG - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   idx_reg, idx_next;
  logic [N_REG-1:0]        busy_reg, busy_next;
  logic [DATA_WIDTH-1:0]   rf [N_REG];

  logic [ADDR_WIDTH-1:0]   wa [NR_WRITE];
  logic [DATA_WIDTH-1:0]   wd [NR_WRITE];
  logic [NR_WRITE-1:0]     we;
  logic                    sweeping;

  assign sweeping = (state_reg == SWEEP);

  // Accepted writes: never to entry 0, never while the sweep owns the array.
  genvar gi;
  generate
    for (gi = 0; gi < NR_WRITE; gi++) begin : g_wport
      assign wa[gi] = bus.waddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wd[gi] = bus.wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign we[gi] = bus.wen[gi] && (wa[gi] != '0) && !sweeping;
    end
  endgenerate

  generate
    for (gi = 0; gi < NR_READ; gi++) begin : g_rport
      logic [ADDR_WIDTH-1:0] ra;
      logic [DATA_WIDTH-1:0] rd;
      logic                  hit;

      assign ra = bus.raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];

      // Later ports override earlier ones, matching write priority.
      always_comb begin
        rd  = rf[ra];
        hit = 1'b0;
        if (BYPASS != 0) begin
          for (int i = 0; i < NR_WRITE; i++) begin
            if (we[i] && (wa[i] == ra)) begin
              rd  = wd[i];
              hit = 1'b1;
            end
          end
        end
        if (ra == '0) begin
          rd = '0;
        end
      end

      assign bus.rdata[gi*DATA_WIDTH +: DATA_WIDTH] = rd;
      assign bus.rbusy[gi] = busy_reg[ra] && !hit && (ra != '0);
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    bus.clr_ready = 1'b0;
    bus.clr_done  = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.clr_ready = 1'b1;
        if (bus.clr_req) begin
          state_next = SWEEP;
          idx_next   = ADDR_WIDTH'(1);
        end
      end
      SWEEP: begin
        idx_next = idx_reg + ADDR_WIDTH'(1);
        if (idx_reg == LAST_IDX) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus.clr_done = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A new producer marked in the same cycle as a write keeps the entry pending.
  always_comb begin
    busy_next = busy_reg;
    if (sweeping) begin
      busy_next[idx_reg] = 1'b0;
    end else begin
      for (int i = 0; i < NR_WRITE; i++) begin
        if (we[i]) begin
          busy_next[wa[i]] = 1'b0;
        end
      end
      if (bus.busy_set && (bus.busy_addr != '0)) begin
        busy_next[bus.busy_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      busy_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      busy_reg  <= busy_next;
    end
  end

  // Array contents survive reset; a partial sweep is left as it stands.
  always_ff @(posedge clk) begin
    if (sweeping) begin
      rf[idx_reg] <= '0;
    end else begin
      for (int i = 0; i < NR_WRITE; i++) begin
        if (we[i]) begin
          rf[wa[i]] <= wd[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a bypassing and a non-bypassing instance
// share stimulus; vector table plus clear/reset/back-to-back sequences.
module tb_regfile_mp;
  localparam int AW = 5;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_READ(2), .NR_WRITE(2)) bus ();
  regfile_mp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_READ(2), .NR_WRITE(2)) bus_nb ();

  assign bus_nb.raddr     = bus.raddr;
  assign bus_nb.wen       = bus.wen;
  assign bus_nb.waddr     = bus.waddr;
  assign bus_nb.wdata     = bus.wdata;
  assign bus_nb.busy_set  = bus.busy_set;
  assign bus_nb.busy_addr = bus.busy_addr;
  assign bus_nb.clr_req   = bus.clr_req;

  regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_READ(2), .NR_WRITE(2), .BYPASS(1))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_READ(2), .NR_WRITE(2), .BYPASS(0))
    dut_nb (.clk(clk), .rst_n(rst_n), .bus(bus_nb));

  typedef struct {
    logic [1:0]  wen;
    logic [4:0]  wa0;
    logic [63:0] wd0;
    logic [4:0]  wa1;
    logic [63:0] wd1;
    logic        bs;
    logic [4:0]  ba;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [63:0] e_rd0;
    logic [63:0] e_rd1;
    logic [1:0]  e_rbusy;
    logic        nb_chk;
    logic [63:0] nb_rd0;
    logic        nb_rbusy0;
  } vec_t;

  vec_t vt [12];
  int checks = 0;
  int errors = 0;
  int low_cnt, done_cnt, done_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] val(input int a);
    return 64'hC0DE_0000_0000_0000 | 64'(a);
  endfunction

  task automatic fill();
    for (int a = 1; a < 32; a += 2) begin
      bus.wen   = (a + 1 < 32) ? 2'b11 : 2'b01;
      bus.waddr = {5'(a + 1), 5'(a)};
      bus.wdata = {val(a + 1), val(a)};
      step();
    end
    bus.wen = 2'b00;
  endtask

  initial begin
    bus.raddr = {5'd4, 5'd3};
    bus.wen = 2'b00; bus.waddr = '0; bus.wdata = '0;
    bus.busy_set = 1'b0; bus.busy_addr = '0; bus.clr_req = 1'b0;

    // Reset state
    #2;
    chk("reset clr_ready", 64'(bus.clr_ready), 64'd1);
    chk("reset clr_done", 64'(bus.clr_done), 64'd0);
    chk("reset rbusy", 64'(bus.rbusy), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    //        wen    wa0   wd0        wa1    wd1         bs    ba    ra0    ra1    e_rd0       e_rd1       e_rbusy nb nb_rd0    nb_rb
    vt[0]  = '{2'b11, 5'd5, 64'h1234,  5'd5,  64'hABCD,  1'b0, 5'd0, 5'd5,  5'd0,  64'hABCD,  64'h0,      2'b00, 1'b0, 64'h0,    1'b0};
    vt[1]  = '{2'b01, 5'd0, 64'hFFFF,  5'd0,  64'h0,     1'b0, 5'd0, 5'd5,  5'd0,  64'hABCD,  64'h0,      2'b00, 1'b1, 64'hABCD, 1'b0};
    vt[2]  = '{2'b11, 5'd3, 64'h30,    5'd7,  64'h11,    1'b0, 5'd0, 5'd0,  5'd5,  64'h0,     64'hABCD,   2'b00, 1'b1, 64'h0,    1'b0};
    vt[3]  = '{2'b01, 5'd7, 64'h55,    5'd0,  64'h0,     1'b0, 5'd0, 5'd7,  5'd3,  64'h55,    64'h30,     2'b00, 1'b1, 64'h11,   1'b0};
    vt[4]  = '{2'b00, 5'd0, 64'h0,     5'd0,  64'h0,     1'b1, 5'd3, 5'd7,  5'd3,  64'h55,    64'h30,     2'b00, 1'b1, 64'h55,   1'b0};
    vt[5]  = '{2'b00, 5'd0, 64'h0,     5'd0,  64'h0,     1'b0, 5'd0, 5'd3,  5'd3,  64'h30,    64'h30,     2'b11, 1'b1, 64'h30,   1'b1};
    vt[6]  = '{2'b10, 5'd0, 64'h0,     5'd3,  64'h3A,    1'b0, 5'd0, 5'd3,  5'd5,  64'h3A,    64'hABCD,   2'b00, 1'b1, 64'h30,   1'b1};
    vt[7]  = '{2'b00, 5'd0, 64'h0,     5'd0,  64'h0,     1'b0, 5'd0, 5'd3,  5'd3,  64'h3A,    64'h3A,     2'b00, 1'b1, 64'h3A,   1'b0};
    vt[8]  = '{2'b01, 5'd3, 64'h3B,    5'd0,  64'h0,     1'b1, 5'd3, 5'd3,  5'd0,  64'h3B,    64'h0,      2'b00, 1'b1, 64'h3A,   1'b0};
    vt[9]  = '{2'b00, 5'd0, 64'h0,     5'd0,  64'h0,     1'b0, 5'd0, 5'd3,  5'd7,  64'h3B,    64'h55,     2'b01, 1'b1, 64'h3B,   1'b1};
    vt[10] = '{2'b11, 5'd9, 64'h90,    5'd10, 64'hA0,    1'b0, 5'd0, 5'd10, 5'd9,  64'hA0,    64'h90,     2'b00, 1'b0, 64'h0,    1'b0};
    vt[11] = '{2'b00, 5'd0, 64'h0,     5'd0,  64'h0,     1'b0, 5'd0, 5'd9,  5'd10, 64'h90,    64'hA0,     2'b00, 1'b1, 64'h90,   1'b0};

    for (int k = 0; k < 12; k++) begin
      bus.wen = vt[k].wen;
      bus.waddr = {vt[k].wa1, vt[k].wa0};
      bus.wdata = {vt[k].wd1, vt[k].wd0};
      bus.busy_set = vt[k].bs;
      bus.busy_addr = vt[k].ba;
      bus.raddr = {vt[k].ra1, vt[k].ra0};
      #2;
      chk($sformatf("v%0d rdata0", k), bus.rdata[63:0], vt[k].e_rd0);
      chk($sformatf("v%0d rdata1", k), bus.rdata[127:64], vt[k].e_rd1);
      chk($sformatf("v%0d rbusy", k), 64'(bus.rbusy), 64'(vt[k].e_rbusy));
      if (vt[k].nb_chk) begin
        chk($sformatf("v%0d nobyp rdata0", k), bus_nb.rdata[63:0], vt[k].nb_rd0);
        chk($sformatf("v%0d nobyp rbusy0", k), 64'(bus_nb.rbusy[0]), 64'(vt[k].nb_rbusy0));
      end
      step();
    end
    bus.wen = 2'b00; bus.busy_set = 1'b0;

    // Full clear with writes and busy_set attempted during the sweep
    fill();
    bus.busy_set = 1'b1; bus.busy_addr = 5'd4;
    step();
    bus.busy_set = 1'b0;
    bus.clr_req = 1'b1;
    #2;
    chk("clear idle clr_ready", 64'(bus.clr_ready), 64'd1);
    step();
    bus.clr_req = 1'b0;
    low_cnt = 0; done_cnt = 0; done_cyc = 0;
    for (int c = 1; c <= 34; c++) begin
      bus.wen = (c == 5 || c == 6) ? 2'b11 : 2'b00;
      bus.waddr = {5'd2, 5'd1};
      bus.wdata = {64'hDEAD, 64'hDEAD};
      bus.busy_set = (c == 5);
      bus.busy_addr = 5'd2;
      bus.raddr = {5'd4, 5'd1};
      #2;
      if (!bus.clr_ready) low_cnt++;
      if (bus.clr_done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c == 2) chk("sweep rbusy x4 pending", 64'(bus.rbusy[1]), 64'd1);
      if (c == 5) chk("sweep no bypass x1", bus.rdata[63:0], 64'd0);
      step();
    end
    bus.wen = 2'b00; bus.busy_set = 1'b0;
    chk("clear ready-low cycles", 64'(low_cnt), 64'd32);
    chk("clear done pulses", 64'(done_cnt), 64'd1);
    chk("clear done cycle", 64'(done_cyc), 64'd32);
    chk("clear ready after", 64'(bus.clr_ready), 64'd1);
    for (int a = 0; a < 32; a += 2) begin
      bus.raddr = {5'(a + 1), 5'(a)};
      #2;
      chk($sformatf("cleared x%0d", a), bus.rdata[63:0], 64'd0);
      chk($sformatf("cleared x%0d", a + 1), bus.rdata[127:64], 64'd0);
      chk($sformatf("cleared rbusy x%0d/x%0d", a, a + 1), 64'(bus.rbusy), 64'd0);
      step();
    end

    // Asynchronous reset in sweep cycle 10
    fill();
    bus.busy_set = 1'b1; bus.busy_addr = 5'd12;
    step();
    bus.busy_set = 1'b0;
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    for (int c = 1; c < 10; c++) step();
    #1;
    chk("sweep cycle 10 clr_ready", 64'(bus.clr_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("async reset clr_ready", 64'(bus.clr_ready), 64'd1);
    chk("async reset clr_done", 64'(bus.clr_done), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    for (int a = 0; a < 32; a += 2) begin
      bus.raddr = {5'(a + 1), 5'(a)};
      #2;
      chk($sformatf("partial x%0d", a), bus.rdata[63:0], (a < 10 && a != 0) ? 64'd0 : ((a == 0) ? 64'd0 : val(a)));
      chk($sformatf("partial x%0d", a + 1), bus.rdata[127:64], (a + 1 < 10) ? 64'd0 : val(a + 1));
      chk($sformatf("partial rbusy x%0d/x%0d", a, a + 1), 64'(bus.rbusy), 64'd0);
      step();
    end

    // clr_req held high: back-to-back clears with one idle cycle between
    bus.clr_req = 1'b1;
    #2;
    chk("b2b start ready", 64'(bus.clr_ready), 64'd1);
    step();
    for (int c = 1; c <= 70; c++) begin
      logic exp_ready, exp_done;
      bus.clr_req = (c <= 40);
      #2;
      exp_ready = !((c >= 1 && c <= 32) || (c >= 34 && c <= 65));
      exp_done  = (c == 32) || (c == 65);
      chk($sformatf("b2b c%0d ready,done", c), 64'({bus.clr_ready, bus.clr_done}), 64'({exp_ready, exp_done}));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
